a3_imm_extend_stage: RTL and testbench

//  Registered, parametrised immediate-extension pipeline stage for the datapath decode->execute path.

---
 rtl/a3_imm_extend_stage.sv | 128 ++++++++++++
 tb/tb_a3_imm_extend_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/a3_imm_extend_stage.sv
// Registered immediate-extension stage with valid/ready handshake and a 2-entry skid buffer.
// Optional output-transfer counter is enabled by defining EXT_COUNT_EN.
module a3_imm_extend_stage #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  unextended,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] extended,
  output logic             mode_err,
  output logic [15:0]      ext_count
);

  localparam int PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } buf_state_t;

  buf_state_t state, state_next;

  logic [OUT_W-1:0] main_data, skid_data, ext_data;
  logic             main_err, skid_err, ext_err;
  logic             in_xfer, out_xfer;
  logic             load_main_in, load_main_skid, load_skid;

  // Extension happens before storage so both buffer entries hold final results.
  always_comb begin
    ext_data = {{PAD{1'b0}}, unextended};
    ext_err  = 1'b0;
    case (mode)
      2'b01:   ext_data = {{PAD{unextended[IN_W-1]}}, unextended};
      2'b10:   ext_data = {unextended, {PAD{1'b0}}};
      2'b11:   ext_err  = 1'b1;
      default: ext_data = {{PAD{1'b0}}, unextended};
    endcase
  end

  // Handshake flags come straight from the state register, so no ready path is combinational.
  assign in_ready  = (state != FULL2);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next   = FULL1;
          load_main_in = 1'b1;
        end
      end
      FULL1: begin
        case ({in_xfer, out_xfer})
          2'b11: load_main_in = 1'b1;
          2'b01: state_next   = EMPTY;
          2'b10: begin
            state_next = FULL2;
            load_skid  = 1'b1;
          end
          default: state_next = FULL1;
        endcase
      end
      FULL2: begin
        if (out_xfer) begin
          state_next     = FULL1;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (load_main_in) begin
        main_data <= ext_data;
        main_err  <= ext_err;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_err  <= ext_err;
      end
    end
  end

  assign extended = main_data;
  assign mode_err = main_err;

`ifdef EXT_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else if (out_xfer) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign ext_count = count_q;
`else
  assign ext_count = 16'd0;
`endif

endmodule

// File: tb/tb_a3_imm_extend_stage.sv
// Directed self-checking bench for a3_imm_extend_stage (IN_W=6, OUT_W=8).
module tb_a3_imm_extend_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] unextended;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] extended;
  logic       mode_err;
  logic [15:0] ext_count;

  int checks = 0;
  int errors = 0;

  a3_imm_extend_stage #(.IN_W(6), .OUT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .unextended(unextended),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .extended(extended),
    .mode_err(mode_err),
    .ext_count(ext_count)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; unextended = '0; mode = 2'b00;
    step(); step();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || extended !== 8'h00 || mode_err !== 1'b0 || ext_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b ext=%h err=%b cnt=%h, need 1 0 00 0 0000",
               in_ready, out_valid, extended, mode_err, ext_count);
    end
  endtask

  task automatic test_modes();
    logic [5:0] imm_v [5] = '{6'b110010, 6'b110010, 6'b110010, 6'b011011, 6'b011011};
    logic [1:0] mode_v[5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
    logic [7:0] exp_v [5] = '{8'h32, 8'hF2, 8'hC8, 8'h1B, 8'h1B};
    logic       err_v [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; unextended = imm_v[i]; mode = mode_v[i];
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || extended !== exp_v[i] || mode_err !== err_v[i]) begin
        errors++;
        $display("[TB] FAIL mode_vec%0d: got vld=%b ext=%h err=%b, need 1 %h %b",
                 i, out_valid, extended, mode_err, exp_v[i], err_v[i]);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mode_drain%0d: got vld=%b, need 0", i, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; mode = 2'b00;
    in_valid = 1'b1; unextended = 6'b110010;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || extended !== 8'h32) begin
      errors++;
      $display("[TB] FAIL bp_first: got rdy=%b vld=%b ext=%h, need 1 1 32", in_ready, out_valid, extended);
    end
    unextended = 6'b011011;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || extended !== 8'h32) begin
      errors++;
      $display("[TB] FAIL bp_full2: got rdy=%b vld=%b ext=%h, need 0 1 32", in_ready, out_valid, extended);
    end
    unextended = 6'h3F;
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || extended !== 8'h32 || mode_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_hold: got rdy=%b ext=%h err=%b, need 0 32 0", in_ready, extended, mode_err);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || extended !== 8'h1B || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_second_out: got vld=%b ext=%h rdy=%b, need 1 1b 1", out_valid, extended, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_third_ignored: got vld=%b ext=%h, need vld 0", out_valid, extended);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    out_ready = 1'b1; mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; unextended = 6'(i * 3 + 1);
      exp_d = 8'(i * 3 + 1);
      step();
      checks++;
      if (out_valid !== 1'b1 || extended !== exp_d || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_item%0d: got vld=%b ext=%h rdy=%b, need 1 %h 1", i, out_valid, extended, in_ready, exp_d);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: got vld=%b, need 0", out_valid);
    end
  endtask

  task automatic test_reset_full2();
    out_ready = 1'b0; mode = 2'b01;
    in_valid = 1'b1; unextended = 6'b110010;
    step();
    unextended = 6'b011011;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_reach_full2: got rdy=%b, need 0", in_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || extended !== 8'h00 || mode_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_full2: got vld=%b rdy=%b ext=%h err=%b, need 0 1 00 0", out_valid, in_ready, extended, mode_err);
    end
    out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || extended !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_no_stale: got vld=%b ext=%h, need 0 00", out_valid, extended);
    end
  endtask

  // Streams n inputs with out_ready high, then drains; every item produces one output transfer.
  task automatic stream(input int n);
    out_ready = 1'b1; mode = 2'b00;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; unextended = 6'(i);
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_count();
    reset = 1'b1;
    step();
    reset = 1'b0;
    stream(5);
`ifdef EXT_COUNT_EN
    checks++;
    if (ext_count !== 16'd5) begin
      errors++;
      $display("[TB] FAIL count_5: got %0d, need 5", ext_count);
    end
    stream(65530);
    checks++;
    if (ext_count !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL count_max: got %h, need ffff", ext_count);
    end
    stream(1);
    checks++;
    if (ext_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL count_wrap: got %h, need 0000", ext_count);
    end
`else
    checks++;
    if (ext_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL count_tied: got %h, need 0000", ext_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_full2();
    test_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
